motor_ramp_pwm: RTL and testbench
=================================

Name: motor_ramp_pwm

Overview:
Parametrised N-channel motor PWM driver that supersedes the fixed two-channel speed table. Each channel has a target duty and direction. The block slews the applied duty toward the target at a bounded rate, and reverses direction only after ramping through zero and holding one zero-duty ramp tick. It sits between the line-following mode decoder and the motor driver pins, and adds soft start/stop, safe reversal and a global enable.

Parameters:
N_CH, 2, number of motor channels
DUTY_W, 10, duty resolution in bits; full scale is 2^DUTY_W
PERIOD, 4000, PWM period in clk cycles (100 MHz / 25 kHz)
RAMP_PERIODS, 1, PWM periods per ramp tick (>=1)
STEP, 128, maximum duty change per ramp tick (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
en  in  1  global enable; 0 forces all channels to zero duty
target_duty  in  N_CH*DUTY_W  per-channel requested duty; channel i occupies bits [i*DUTY_W +: DUTY_W]
target_dir  in  N_CH  per-channel requested direction (0 = forward)
pwm  out  N_CH  PWM outputs
dir  out  N_CH  applied direction, registered
cur_duty  out  N_CH*DUTY_W  applied (ramped) duty, registered
frame  out  1  one-cycle pulse in the cycle where cnt==0
settled  out  N_CH  cur_duty==target_duty and dir==target_dir, combinational from registers

Behaviour:
- Reset (async, rst_n=0):
  - cnt, ramp divider, cur_duty, thr, pwm, frame all 0.
  - dir all 0.
  - Takes effect immediately, including mid-period or mid-ramp.
- Period counter cnt runs 0..PERIOD-1 and wraps to 0. frame = (cnt==0).
- Ramp divider:
  - Counts wraps (edges where cnt==PERIOD-1).
  - A ramp tick occurs on the wrap edge that completes every RAMP_PERIODS-th period.
- Per channel, on a tick edge with en=1, targets are sampled and:
  - target_dir != dir and cur > 0: cur -= min(STEP, cur).
  - target_dir != dir and cur == 0: dir <= target_dir; cur stays 0 (dead tick).
  - target_dir == dir: cur moves toward target_duty by at most STEP and never overshoots. If cur == target, it is unchanged.
- Targets are ignored between ticks; changing them mid-period never alters the current period.
- Threshold latch:
  - thr[i] = (cur[i] * PERIOD) >> DUTY_W, latched on the edge where cnt==0, so it uses the value cur took at the preceding wrap.
  - The intermediate product must be DUTY_W+clog2(PERIOD+1) bits wide; no truncation before the shift.
- PWM output:
  - pwm[i] is registered: pwm[i] <= en && (cnt < thr[i]). One cycle of latency from cnt.
  - Duty 0 gives a constant low. Full scale (2^DUTY_W-1) gives high for thr cycles and is never 100%.
- en=0:
  - On the next edge, all cur <= 0, thr <= 0 and pwm <= 0.
  - dir holds its value. The ramp divider clears; cnt keeps running.
  - On en rising, channels ramp up from 0 starting with the next tick.
- Simultaneous events:
  - rst_n overrides everything.
  - en=0 overrides a ramp tick on the same edge.
  - Reversal and ramp rules are evaluated independently per channel.
- Channels never interact; the period counter is shared so all PWM edges are phase-aligned.

Test Plan:
Bench parameters: N_CH=2, DUTY_W=10, PERIOD=1024, RAMP_PERIODS=1, STEP=128, giving thr==cur.
1. Reset: drive rst_n low mid-period while cur=500 and pwm=1 -> pwm, cur_duty, dir and frame read 0 before the next clk edge. They stay 0 while rst_n is low.
2. Ramp up: en=1, ch0 target 500 dir 0 -> cur_duty[0] reads 128, 256, 384, 500 on successive ticks, then settled[0]=1. Each steady period has pwm[0] high for exactly 500 of 1024 cycles. ch1 stays 0.
3. Ramp down and mid-period change: change the target from 500 to 100 at cnt=300 -> the current period still has 500 high cycles. Then cur reads 372, 244, 116, 100.
4. Reversal: from cur 300 dir 0, target dir 1 duty 200 -> cur reads 172, 44, 0. On the next tick dir becomes 1 and cur stays 0. cur then reads 128, 200. pwm[0] stays low for the whole dead period.
5. Enable drop: with cur 500, drop en at cnt=100 -> pwm and cur read 0 one edge later. Re-enable -> the ramp restarts 128, 256, …. Repeat with RAMP_PERIODS=3 and check ticks are exactly 3 frames apart.
6. Extremes: ch0 target 1023, ch1 target 0 -> once steady, ch0 is high for 1023 of 1024 cycles and ch1 never goes high. frame pulses exactly once every 1024 cycles.

Source files
------------

// File: rtl/motor_ramp_pwm.sv
// ---------------------------------------------------------------------------
// motor_ramp_pwm
//
// N-channel motor PWM driver with slew-limited duty and safe reversal.
// Every channel chases its requested duty and direction, but the applied duty
// moves by at most STEP per ramp tick. A direction change first ramps the
// duty down to zero. The channel then spends one whole ramp tick at zero duty
// before the new direction is applied. A global enable forces zero duty
// immediately. The applied direction is kept while the enable is low, so
// re-enabling never causes a surprise reversal.
//
// All channels share one period counter, so every PWM rising edge is
// phase-aligned.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   en           global enable; low forces all channels to zero duty
//   target_duty  requested duty, channel i at [i*DUTY_W +: DUTY_W]
//   target_dir   requested direction per channel (0 = forward)
//   pwm          registered PWM outputs
//   dir          applied direction per channel, registered
//   cur_duty     applied (ramped) duty per channel, registered
//   frame        one-cycle pulse in the cycle where the period counter is 0
//   settled      applied duty and direction equal the request, per channel
// ---------------------------------------------------------------------------
module motor_ramp_pwm #(
    parameter int N_CH         = 2,
    parameter int DUTY_W       = 10,
    parameter int PERIOD       = 4000,
    parameter int RAMP_PERIODS = 1,
    parameter int STEP         = 128
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [N_CH*DUTY_W-1:0]   target_duty,
    input  logic [N_CH-1:0]          target_dir,
    output logic [N_CH-1:0]          pwm,
    output logic [N_CH-1:0]          dir,
    output logic [N_CH*DUTY_W-1:0]   cur_duty,
    output logic                     frame,
    output logic [N_CH-1:0]          settled
);

    localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int RDIV_W = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;

    // The duty*PERIOD product keeps its full width so that nothing is lost
    // before the shift. The threshold keeps the same width, and the counter
    // is zero-extended to it for the compare.
    localparam int PROD_W = DUTY_W + $clog2(PERIOD + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PERIOD - 1);
    localparam logic [RDIV_W-1:0] RDIV_LAST = RDIV_W'(RAMP_PERIODS - 1);
    localparam logic [PROD_W-1:0] PERIOD_V  = PROD_W'(PERIOD);

    // A step larger than full scale behaves exactly like full scale, so the
    // step is clamped to fit the DUTY_W+1-bit arithmetic below.
    localparam int STEP_C = (STEP > (1 << DUTY_W)) ? (1 << DUTY_W) : STEP;
    localparam logic [DUTY_W:0] STEP_V = (DUTY_W + 1)'(STEP_C);

    logic [CNT_W-1:0]  r_cnt;
    logic [RDIV_W-1:0] r_rdiv;
    logic              r_frame;
    logic              w_wrap;
    logic              w_tick;
    logic              w_cntZero;

    // One ramp step for a single channel. When reversing, the duty only
    // falls toward zero. Otherwise it moves toward the target without
    // overshooting it. The arithmetic is one bit wider than the duty, so
    // cur+STEP cannot wrap.
    function automatic logic [DUTY_W-1:0] f_nextCur(
        input logic [DUTY_W-1:0] cur,
        input logic [DUTY_W-1:0] tgt,
        input logic              reverse
    );
        logic [DUTY_W:0]   c;
        logic [DUTY_W:0]   t;
        logic [DUTY_W-1:0] res;
        c   = {1'b0, cur};
        t   = {1'b0, tgt};
        res = cur;
        if (reverse) begin
            if (c > STEP_V) begin
                res = DUTY_W'(c - STEP_V);
            end else begin
                res = '0;
            end
        end else if (t > c) begin
            if ((t - c) > STEP_V) begin
                res = DUTY_W'(c + STEP_V);
            end else begin
                res = tgt;
            end
        end else if (c > t) begin
            if ((c - t) > STEP_V) begin
                res = DUTY_W'(c - STEP_V);
            end else begin
                res = tgt;
            end
        end
        return res;
    endfunction

    assign w_wrap    = (r_cnt == CNT_LAST);
    assign w_tick    = w_wrap && (r_rdiv == RDIV_LAST);
    assign w_cntZero = (r_cnt == '0);
    assign frame     = r_frame;

    // Free-running period counter. It keeps counting while the enable is low
    // so that PWM phase never shifts. The frame pulse is registered from the
    // wrap condition, so it is high exactly while the counter reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_frame <= 1'b0;
        end else begin
            r_frame <= w_wrap;
            if (w_wrap) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Ramp divider. It counts period wraps, and its last count marks a ramp
    // tick. It is cleared while disabled, so a re-enable always waits a full
    // RAMP_PERIODS before the first step up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdiv <= '0;
        end else if (!en) begin
            r_rdiv <= '0;
        end else if (w_wrap) begin
            if (r_rdiv == RDIV_LAST) begin
                r_rdiv <= '0;
            end else begin
                r_rdiv <= r_rdiv + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [DUTY_W-1:0] w_tgt;
        logic              w_rev;
        logic [DUTY_W-1:0] w_nextCur;
        logic [PROD_W-1:0] w_thrNext;
        logic [DUTY_W-1:0] r_cur;
        logic              r_dir;
        logic [PROD_W-1:0] r_thr;
        logic              r_pwm;

        assign w_tgt     = target_duty[g*DUTY_W +: DUTY_W];
        assign w_rev     = (target_dir[g] != r_dir);
        assign w_nextCur = f_nextCur(r_cur, w_tgt, w_rev);
        assign w_thrNext = (PROD_W'(r_cur) * PERIOD_V) >> DUTY_W;

        // Applied duty and direction. Targets are only looked at on a tick.
        // The direction flips only when a reversal is requested and the duty
        // is already zero, which makes that tick the dead tick at zero duty.
        // A low enable wins over a tick on the same edge.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cur <= '0;
                r_dir <= 1'b0;
            end else if (!en) begin
                r_cur <= '0;
            end else if (w_tick) begin
                r_cur <= w_nextCur;
                if (w_rev && (r_cur == '0)) begin
                    r_dir <= target_dir[g];
                end
            end
        end

        // The compare threshold is latched once per period, at the counter-zero
        // edge, from the duty the preceding wrap produced. This means a duty
        // change never reshapes a period that is already running. The PWM
        // output is the registered compare, one cycle behind the counter.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_thr <= '0;
                r_pwm <= 1'b0;
            end else if (!en) begin
                r_thr <= '0;
                r_pwm <= 1'b0;
            end else begin
                if (w_cntZero) begin
                    r_thr <= w_thrNext;
                end
                r_pwm <= (PROD_W'(r_cnt) < r_thr);
            end
        end

        assign cur_duty[g*DUTY_W +: DUTY_W] = r_cur;
        assign dir[g]     = r_dir;
        assign pwm[g]     = r_pwm;
        assign settled[g] = (r_cur == w_tgt) && (r_dir == target_dir[g]);
    end

endmodule

// File: tb/tb_motor_ramp_pwm.sv
// ---------------------------------------------------------------------------
// tb_motor_ramp_pwm
//
// Directed bench for motor_ramp_pwm. PERIOD=1024 and DUTY_W=10, so the
// threshold equals the applied duty. Instance dut uses RAMP_PERIODS=1.
// Instance dutSlow uses RAMP_PERIODS=3 and has fixed targets, and it is used
// to check the tick spacing after a re-enable.
// ---------------------------------------------------------------------------
module tb_motor_ramp_pwm;

    localparam int N_CH   = 2;
    localparam int DUTY_W = 10;
    localparam int PERIOD = 1024;
    localparam int STEP   = 128;

    localparam logic [N_CH*DUTY_W-1:0] TGT_SLOW = {10'd0, 10'd500};
    localparam logic [N_CH-1:0]        DIR_SLOW = 2'b00;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   en = 1'b0;
    logic                   enSlow = 1'b0;
    logic [N_CH*DUTY_W-1:0] tgtDuty = '0;
    logic [N_CH-1:0]        tgtDir = '0;

    logic [N_CH-1:0]        pwm;
    logic [N_CH-1:0]        dir;
    logic [N_CH*DUTY_W-1:0] curDuty;
    logic                   frame;
    logic [N_CH-1:0]        settled;

    logic [N_CH-1:0]        pwmSlow;
    logic [N_CH-1:0]        dirSlow;
    logic [N_CH*DUTY_W-1:0] curDutySlow;
    logic                   frameSlow;
    logic [N_CH-1:0]        settledSlow;

    int checks = 0;
    int errors = 0;

    int h0;
    int h1;
    int fr;

    int expFast [6] = '{128, 256, 384, 500, 500, 500};
    int expSlow [6] = '{0, 0, 128, 128, 128, 256};

    always #5 clk = ~clk;

    motor_ramp_pwm #(
        .N_CH(N_CH), .DUTY_W(DUTY_W), .PERIOD(PERIOD),
        .RAMP_PERIODS(1), .STEP(STEP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .target_duty(tgtDuty), .target_dir(tgtDir),
        .pwm(pwm), .dir(dir), .cur_duty(curDuty),
        .frame(frame), .settled(settled)
    );

    motor_ramp_pwm #(
        .N_CH(N_CH), .DUTY_W(DUTY_W), .PERIOD(PERIOD),
        .RAMP_PERIODS(3), .STEP(STEP)
    ) dutSlow (
        .clk(clk), .rst_n(rst_n), .en(enSlow),
        .target_duty(TGT_SLOW), .target_dir(DIR_SLOW),
        .pwm(pwmSlow), .dir(dirSlow), .cur_duty(curDutySlow),
        .frame(frameSlow), .settled(settledSlow)
    );

    // One comparison: count it, and on mismatch count and report it.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive enable and both channel requests from the current negedge.
    task automatic applyStimulus(input logic enV,
                                 input logic [9:0] d0, input logic r0,
                                 input logic [9:0] d1, input logic r1);
        en      = enV;
        tgtDuty = {d1, d0};
        tgtDir  = {r1, r0};
    endtask

    // Advance to the next negedge that has frame high, which is the cycle
    // where cnt==0. Ticks have already updated cur_duty by this point. The
    // wait is bounded, and a timeout counts as a failed comparison.
    task automatic waitFrame();
        int n;
        n = 0;
        @(negedge clk);
        while (frame !== 1'b1 && n < 2100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("frameSeen", 32'(frame), 32'd1);
    endtask

    // Sample PERIOD consecutive negedges, starting with the current one, and
    // count pwm highs per channel and frame pulses. Ch0 target is changed at
    // sample midAt when midAt >= 0.
    task automatic countHigh(input int midAt, input logic [9:0] midTgt,
                             output int c0, output int c1, output int cf);
        c0 = 0;
        c1 = 0;
        cf = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (i > 0) @(negedge clk);
            if (i == midAt) tgtDuty[9:0] = midTgt;
            c0 = c0 + (pwm[0] ? 1 : 0);
            c1 = c1 + (pwm[1] ? 1 : 0);
            cf = cf + (frame ? 1 : 0);
        end
    endtask

    initial begin
        $display("[TB] reset held");
        repeat (3) @(negedge clk);
        checkOutput("rstPwm", 32'(pwm), 32'd0);
        checkOutput("rstCur", 32'(curDuty), 32'd0);
        checkOutput("rstDir", 32'(dir), 32'd0);
        checkOutput("rstFrame", 32'(frame), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("postRstFrame", 32'(frame), 32'd0);
        checkOutput("postRstCur", 32'(curDuty), 32'd0);

        $display("[TB] ramp up to 500");
        applyStimulus(1'b1, 10'd500, 1'b0, 10'd0, 1'b0);
        waitFrame();
        checkOutput("up128", 32'(curDuty[9:0]), 32'd128);
        checkOutput("upCh1", 32'(curDuty[19:10]), 32'd0);
        waitFrame();
        checkOutput("up256", 32'(curDuty[9:0]), 32'd256);
        waitFrame();
        checkOutput("up384", 32'(curDuty[9:0]), 32'd384);
        waitFrame();
        checkOutput("up500", 32'(curDuty[9:0]), 32'd500);
        checkOutput("upSettled", 32'(settled), 32'd3);
        waitFrame();
        countHigh(-1, 10'd0, h0, h1, fr);
        checkOutput("high500", 32'(h0), 32'd500);
        checkOutput("highCh1Zero", 32'(h1), 32'd0);

        $display("[TB] ramp down with mid-period target change");
        waitFrame();
        countHigh(300, 10'd100, h0, h1, fr);
        checkOutput("midChangeHigh", 32'(h0), 32'd500);
        waitFrame();
        checkOutput("down372", 32'(curDuty[9:0]), 32'd372);
        waitFrame();
        checkOutput("down244", 32'(curDuty[9:0]), 32'd244);
        waitFrame();
        checkOutput("down116", 32'(curDuty[9:0]), 32'd116);
        waitFrame();
        checkOutput("down100", 32'(curDuty[9:0]), 32'd100);

        $display("[TB] reversal");
        applyStimulus(1'b1, 10'd300, 1'b0, 10'd0, 1'b0);
        waitFrame();
        checkOutput("pre228", 32'(curDuty[9:0]), 32'd228);
        waitFrame();
        checkOutput("pre300", 32'(curDuty[9:0]), 32'd300);
        applyStimulus(1'b1, 10'd200, 1'b1, 10'd0, 1'b0);
        waitFrame();
        checkOutput("rev172", 32'(curDuty[9:0]), 32'd172);
        checkOutput("rev172Dir", 32'(dir[0]), 32'd0);
        waitFrame();
        checkOutput("rev44", 32'(curDuty[9:0]), 32'd44);
        waitFrame();
        checkOutput("rev0", 32'(curDuty[9:0]), 32'd0);
        checkOutput("rev0Dir", 32'(dir[0]), 32'd0);
        checkOutput("rev0Settled", 32'(settled[0]), 32'd0);
        waitFrame();
        checkOutput("deadCur", 32'(curDuty[9:0]), 32'd0);
        checkOutput("deadDir", 32'(dir[0]), 32'd1);
        countHigh(-1, 10'd0, h0, h1, fr);
        checkOutput("deadHigh", 32'(h0), 32'd0);
        waitFrame();
        checkOutput("rev128", 32'(curDuty[9:0]), 32'd128);
        waitFrame();
        checkOutput("rev200", 32'(curDuty[9:0]), 32'd200);
        checkOutput("revSettled", 32'(settled[0]), 32'd1);

        $display("[TB] enable drop");
        applyStimulus(1'b1, 10'd500, 1'b1, 10'd0, 1'b0);
        waitFrame();
        checkOutput("en328", 32'(curDuty[9:0]), 32'd328);
        waitFrame();
        checkOutput("en456", 32'(curDuty[9:0]), 32'd456);
        waitFrame();
        checkOutput("en500", 32'(curDuty[9:0]), 32'd500);
        waitFrame();
        repeat (100) @(negedge clk);
        checkOutput("enPwmHigh", 32'(pwm[0]), 32'd1);
        applyStimulus(1'b0, 10'd500, 1'b1, 10'd0, 1'b0);
        @(negedge clk);
        checkOutput("offPwm", 32'(pwm), 32'd0);
        checkOutput("offCur", 32'(curDuty), 32'd0);
        checkOutput("offDirHeld", 32'(dir[0]), 32'd1);
        repeat (50) @(negedge clk);
        checkOutput("offPwmStill", 32'(pwm), 32'd0);
        applyStimulus(1'b1, 10'd500, 1'b1, 10'd0, 1'b0);
        enSlow = 1'b1;
        for (int k = 0; k < 6; k++) begin
            waitFrame();
            checkOutput($sformatf("reEnFast%0d", k), 32'(curDuty[9:0]),
                        32'(expFast[k]));
            checkOutput($sformatf("reEnSlow%0d", k), 32'(curDutySlow[9:0]),
                        32'(expSlow[k]));
        end

        $display("[TB] extremes");
        applyStimulus(1'b1, 10'd1023, 1'b1, 10'd0, 1'b0);
        waitFrame();
        checkOutput("ext628", 32'(curDuty[9:0]), 32'd628);
        waitFrame();
        checkOutput("ext756", 32'(curDuty[9:0]), 32'd756);
        waitFrame();
        checkOutput("ext884", 32'(curDuty[9:0]), 32'd884);
        waitFrame();
        checkOutput("ext1012", 32'(curDuty[9:0]), 32'd1012);
        waitFrame();
        checkOutput("ext1023", 32'(curDuty[9:0]), 32'd1023);
        waitFrame();
        countHigh(-1, 10'd0, h0, h1, fr);
        checkOutput("fullHigh", 32'(h0), 32'd1023);
        checkOutput("fullCh1Zero", 32'(h1), 32'd0);
        checkOutput("framesPerPeriod", 32'(fr), 32'd1);

        $display("[TB] asynchronous reset mid-period");
        repeat (200) @(negedge clk);
        checkOutput("preRstPwm", 32'(pwm[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncPwm", 32'(pwm), 32'd0);
        checkOutput("asyncCur", 32'(curDuty), 32'd0);
        checkOutput("asyncDir", 32'(dir), 32'd0);
        checkOutput("asyncFrame", 32'(frame), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("heldPwm", 32'(pwm), 32'd0);
        checkOutput("heldCur", 32'(curDuty), 32'd0);
        checkOutput("heldFrame", 32'(frame), 32'd0);
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
